// File: rtl/vscale_htif_host.sv
//------------------------------------------------------------------------------
// Module   : vscale_htif_host
// Purpose  : Host-side initiator for the vscale HTIF PCR interface. Polls the
//            tohost CSR, decodes the riscv-tests completion code, clears
//            tohost with a write of zero and reports done/pass/fail_code.
// Ports    : clk, reset (async, active-high), enable
//            htif_pcr_req_{valid,ready,rw,addr,data}  - request channel
//            htif_pcr_resp_{valid,ready,data}          - response channel
//            done, pass, fail_code, timeout            - sticky status
// Options  : `define VSCALE_HTIF_HOST_TIMEOUT_EN builds a response timeout
//            counter (TIMEOUT_CYC cycles); otherwise timeout is tied to 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vscale_htif_host #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 12'h780,
  parameter int                POLL_GAP    = 16,
  parameter int                TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              htif_pcr_req_valid,
  input  logic              htif_pcr_req_ready,
  output logic              htif_pcr_req_rw,
  output logic [ADDR_W-1:0] htif_pcr_req_addr,
  output logic [DATA_W-1:0] htif_pcr_req_data,
  input  logic              htif_pcr_resp_valid,
  output logic              htif_pcr_resp_ready,
  input  logic [DATA_W-1:0] htif_pcr_resp_data,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-2:0] fail_code,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_WAIT_RD = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WAIT_WR = 3'd4,
    S_GAP     = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [15:0]       c_GAP_LOAD = 16'(POLL_GAP);
  localparam logic              c_GAP_ZERO = (POLL_GAP == 0);
  localparam logic [DATA_W-1:0] c_PASS_VAL = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_val;
  logic [15:0]         r_gap;
  logic                r_done;
  logic                r_pass;
  logic [DATA_W-2:0]   r_fail_code;

  logic                w_req_valid;
  logic                w_req_rw;
  logic                w_resp_ready;
  logic                w_rd_zero;
  logic                w_in_wait;
  logic                w_to_hit;

  assign w_rd_zero = (htif_pcr_resp_data == '0);
  assign w_in_wait = (r_state == S_WAIT_RD) || (r_state == S_WAIT_WR);

  //--------------------------------------------------------------------------
  // Optional response timeout. The counter is held at zero outside the wait
  // states, so it restarts on every entry to WAIT_RD/WAIT_WR. A response that
  // arrives on the final cycle wins over the timeout.
  //--------------------------------------------------------------------------
`ifdef VSCALE_HTIF_HOST_TIMEOUT_EN
  localparam logic [31:0] c_TO_LAST = 32'(TIMEOUT_CYC - 1);

  logic [31:0] r_to_cnt;
  logic        r_timeout;

  assign w_to_hit = w_in_wait && !htif_pcr_resp_valid && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_in_wait) begin
        r_to_cnt <= '0;
      end else if (!w_to_hit) begin
        r_to_cnt <= r_to_cnt + 32'd1;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;
`else
  // Keeps the timeout parameter referenced in builds without the counter.
  logic w_unused_to_cfg;
  assign w_unused_to_cfg = ^32'(TIMEOUT_CYC);
  assign w_to_hit        = 1'b0;
  assign timeout         = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // FSM state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM next state and handshake outputs. Request outputs are pure functions
  // of the registered state, so they cannot change until the state leaves
  // RD_REQ/WR_REQ, which only happens on a transfer.
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = 1'b0;
    w_req_rw     = 1'b0;
    w_resp_ready = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable && !r_done) begin
          w_state_nxt = S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        w_req_valid = 1'b1;
        if (htif_pcr_req_ready) begin
          w_state_nxt = S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        w_resp_ready = 1'b1;
        if (htif_pcr_resp_valid) begin
          if (!w_rd_zero) begin
            w_state_nxt = S_WR_REQ;
          end else if (c_GAP_ZERO) begin
            // No idle gap configured: poll again straight away.
            w_state_nxt = enable ? S_RD_REQ : S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
          end
        end else if (w_to_hit) begin
          w_state_nxt = S_DONE;
        end
      end

      S_WR_REQ: begin
        w_req_valid = 1'b1;
        w_req_rw    = 1'b1;
        if (htif_pcr_req_ready) begin
          w_state_nxt = S_WAIT_WR;
        end
      end

      S_WAIT_WR: begin
        w_resp_ready = 1'b1;
        if (htif_pcr_resp_valid || w_to_hit) begin
          w_state_nxt = S_DONE;
        end
      end

      S_GAP: begin
        // r_gap was loaded with POLL_GAP (>=1 here), so GAP lasts exactly
        // POLL_GAP cycles before the next read is issued.
        if (r_gap <= 16'd1) begin
          w_state_nxt = enable ? S_RD_REQ : S_IDLE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_DONE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Datapath: captured tohost value, poll-gap counter and sticky status.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_val       <= '0;
      r_gap       <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= '0;
    end else begin
      if ((r_state == S_WAIT_RD) && htif_pcr_resp_valid) begin
        r_val <= htif_pcr_resp_data;
      end

      if ((r_state == S_WAIT_RD) && htif_pcr_resp_valid && w_rd_zero) begin
        r_gap <= c_GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap != 16'd0)) begin
        r_gap <= r_gap - 16'd1;
      end

      if ((r_state == S_WAIT_WR) && htif_pcr_resp_valid) begin
        r_done      <= 1'b1;
        r_pass      <= (r_val == c_PASS_VAL);
        r_fail_code <= r_val[DATA_W-1:1];
      end else if (w_to_hit) begin
        r_done      <= 1'b1;
        r_pass      <= 1'b0;
        r_fail_code <= '0;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Output assignments. Address is fixed; write data is always zero because
  // the only write ever issued is the tohost clear.
  //--------------------------------------------------------------------------
  assign htif_pcr_req_valid  = w_req_valid;
  assign htif_pcr_req_rw     = w_req_rw;
  assign htif_pcr_req_addr   = TOHOST_ADDR;
  assign htif_pcr_req_data   = '0;
  assign htif_pcr_resp_ready = w_resp_ready;
  assign done                = r_done;
  assign pass                = r_pass;
  assign fail_code           = r_fail_code;

endmodule

`default_nettype wire

// File: doc/vscale_htif_host.md
Name: vscale_htif_host

Overview:
- Host-side initiator for the HTIF PCR request/response interface of vscale_top.
- Polls the tohost CSR through HTIF, decodes riscv-tests completion codes, clears tohost, and reports done/pass to the bench or SoC harness.
- Connects directly to vscale_top htif_pcr_* ports, replacing tied-off constants.

Parameters:
- ADDR_W, 12, PCR address width.
- DATA_W, 64, PCR data width.
- TOHOST_ADDR, 12'h780, CSR address polled (CSR_ADDR_TO_HOST).
- POLL_GAP, 16, idle cycles between consecutive reads; legal range 0..65535.
- TIMEOUT_CYC, 100000, response timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  start or continue polling while high
- htif_pcr_req_valid  out  1  request valid
- htif_pcr_req_ready  in  1  core accepts request
- htif_pcr_req_rw  out  1  1=write, 0=read
- htif_pcr_req_addr  out  ADDR_W  CSR address, always TOHOST_ADDR
- htif_pcr_req_data  out  DATA_W  write data, 0 for reads and for the clear write
- htif_pcr_resp_valid  in  1  response valid
- htif_pcr_resp_ready  out  1  host accepts response
- htif_pcr_resp_data  in  DATA_W  response data
- done  out  1  sticky; test finished
- pass  out  1  sticky; valid when done=1
- fail_code  out  DATA_W-1  tohost[DATA_W-1:1] captured on completion
- timeout  out  1  sticky; response timeout (feature only, else tied 0)

Behaviour:
- Reset values: all outputs 0; req_addr = TOHOST_ADDR; FSM in IDLE; gap counter 0.
- Request handshake: transfer when req_valid && req_ready. Once asserted, req_valid, rw, addr and data hold stable until the transfer. Reset is the only exception.
- Response handshake: transfer when resp_valid && resp_ready. resp_ready is 1 only in WAIT_RD and WAIT_WR. A response arriving in any other state is ignored and does not advance the FSM.
- Outstanding requests: at most one at a time.
- FSM states and transitions:
  - IDLE: go to RD_REQ when enable=1 && done=0.
  - RD_REQ: req_valid=1, rw=0, data=0. Go to WAIT_RD on transfer.
  - WAIT_RD: on response, capture resp_data into val.
    - val==0: go to GAP and load gap counter with POLL_GAP.
    - val!=0: go to WR_REQ.
  - WR_REQ: req_valid=1, rw=1, data=0 (clears tohost). Go to WAIT_WR on transfer.
  - WAIT_WR: on response (data ignored), go to DONE.
    - Set done=1.
    - pass = (val==1).
    - fail_code = val[DATA_W-1:1].
  - GAP: decrement counter each cycle. When it reaches 0, go to RD_REQ if enable=1, else IDLE. POLL_GAP=0 means RD_REQ is reached on the next cycle.
  - DONE: terminal; only reset leaves it. No further requests.
- enable deasserted mid-transaction: the in-flight request/response completes. The FSM then returns to IDLE instead of issuing a new read.
- Same-cycle events: req_ready high in the same cycle req_valid rises counts as a transfer (zero-wait). A response may arrive the cycle after the request transfer.
- Latency: minimum 1 cycle from enable=1 to req_valid; minimum 4 cycles from a nonzero read request transfer to done (RD xfer, resp, WR xfer, resp).
- Reset mid-operation: asynchronous return to IDLE, outputs cleared. Any in-flight core response is ignored after reset.

Optional Feature:
- Macro: VSCALE_HTIF_HOST_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in WAIT_RD and WAIT_WR. It reloads on entry to either state.
  - Reaching TIMEOUT_CYC without a response sets timeout=1, done=1, pass=0, fail_code=0, and the FSM moves to DONE.
- Without the macro: no counter is built, timeout is tied 0, and the host waits indefinitely.

Test Plan:
- Zero-wait pass: model returns 0 for three reads, then 1; POLL_GAP=2 -> exactly 4 reads and 1 write (data 0) issued; done=1, pass=1, fail_code=0.
- Fail code: tohost read returns 64'h0000_0000_0000_0007 -> write of 0 issued; done=1, pass=0, fail_code=3.
- Backpressure: req_ready low for 5 cycles, then high -> req_valid/rw/addr/data stable all 5 cycles; exactly one transfer; resp_ready=0 outside WAIT states.
- Enable drop: enable falls during WAIT_RD with read data 0 -> FSM returns to IDLE, no further req_valid. Enable rises again -> polling resumes with a read.
- Reset mid-write: reset asserted in WAIT_WR -> all outputs 0 immediately (asynchronously). After release, done=0 and polling restarts from IDLE.
- Timeout (macro defined, TIMEOUT_CYC=50): no response to the first read -> at cycle 50 of WAIT_RD, timeout=1, done=1, pass=0.
